// File: rtl/ysyx_25020047_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25020047_pkg
//  Brief    : Shared types and constants for the LSU: one-hot instruction
//             codes, FSM state encoding and byte-mask width.
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_25020047_pkg;

   localparam int XLEN   = 32;
   localparam int MASK_W = XLEN / 8;

   // One-hot opcode encoding delivered by the EXU
   localparam logic [31:0] INST_LW  = 32'h0000_0020;
   localparam logic [31:0] INST_LBU = 32'h0000_0040;
   localparam logic [31:0] INST_SW  = 32'h0000_0080;
   localparam logic [31:0] INST_SB  = 32'h0000_0100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Byte-wide accesses are the only sub-word widths this LSU supports
   function automatic logic is_byte_access(input logic [31:0] inst_type);
      return |(inst_type & (INST_LBU | INST_SB));
   endfunction

endpackage : ysyx_25020047_pkg
`default_nettype wire

// File: rtl/ysyx_25020047_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25020047_lsu_align
//  Brief    : Combinational lane steering. Extracts a zero-extended byte from
//             a read word and builds store data / byte strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_lsu_align
   import ysyx_25020047_pkg::*;
(
   input  logic [1:0]        i_addr_lo,
   input  logic              i_byte,
   input  logic [XLEN-1:0]   i_wdata,
   input  logic [XLEN-1:0]   i_rdata,
   output logic [XLEN-1:0]   o_st_data,
   output logic [MASK_W-1:0] o_st_mask,
   output logic [XLEN-1:0]   o_ld_data
);

   logic [7:0] w_lane;

   // Pick the addressed byte lane of the read word
   always_comb begin
      w_lane = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_lane = i_rdata[7:0];
         2'd1:    w_lane = i_rdata[15:8];
         2'd2:    w_lane = i_rdata[23:16];
         default: w_lane = i_rdata[31:24];
      endcase
   end

   // Width-dependent load result and store packing
   always_comb begin
      o_ld_data = i_rdata;
      o_st_data = i_wdata;
      o_st_mask = 4'hF;
      if (i_byte) begin
         o_ld_data = {24'h0, w_lane};
         o_st_data = {4{i_wdata[7:0]}};
         o_st_mask = 4'b0001 << i_addr_lo;
      end
   end

endmodule : ysyx_25020047_lsu_align
`default_nettype wire

// File: rtl/ysyx_25020047_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25020047_lsu
//  Brief    : Load/store unit between EXU and WBU. Runs a req/gnt +
//             rvalid transaction for memory ops and passes other results
//             through with one cycle of latency.
//  Options  : YSYX_25020047_LSU_MISALIGN_CHK_EN - flag misaligned lw/sw
//             via out_err instead of issuing the access.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_lsu
   import ysyx_25020047_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   // EXU side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst_type,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic              in_read,
   input  logic              in_write,
   input  logic              in_reg_wen,
   // WBU side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_wb_data,
   output logic              out_reg_wen,
   output logic              out_err,
   // Data-memory port
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_wen,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);

   lsu_state_e        r_state;
   lsu_state_e        w_state_nxt;

   logic [1:0]        r_addr_lo;
   logic              r_is_byte;
   logic              r_write;
   logic [XLEN-1:0]   r_mem_addr;
   logic              r_mem_wen;
   logic [XLEN-1:0]   r_mem_wdata;
   logic [MASK_W-1:0] r_mem_wmask;
   logic [XLEN-1:0]   r_wb_data;
   logic              r_reg_wen;
   logic              r_err;

   logic              w_accept;
   logic              w_mem_op;
   logic              w_is_byte;
   logic              w_misalign;
   logic              w_rsp;
   logic              w_idle;
   logic [1:0]        w_al_addr_lo;
   logic              w_al_byte;
   logic [XLEN-1:0]   w_st_data;
   logic [MASK_W-1:0] w_st_mask;
   logic [XLEN-1:0]   w_ld_data;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_accept  = w_idle & in_valid;
   assign w_mem_op  = in_read | in_write;
   assign w_is_byte = is_byte_access(in_inst_type);

`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
   assign w_misalign = w_mem_op & ~w_is_byte & (in_addr[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   // A response counts only while a transaction is actually outstanding
   assign w_rsp = mem_rvalid & (((r_state == ST_REQ) & mem_gnt) | (r_state == ST_RESP));

   // Store packing uses the incoming operands at accept time; load
   // extraction uses the captured address while the response arrives.
   assign w_al_addr_lo = w_idle ? in_addr[1:0] : r_addr_lo;
   assign w_al_byte    = w_idle ? w_is_byte    : r_is_byte;

   ysyx_25020047_lsu_align u_align (
      .i_addr_lo (w_al_addr_lo),
      .i_byte    (w_al_byte),
      .i_wdata   (in_wdata),
      .i_rdata   (mem_rdata),
      .o_st_data (w_st_data),
      .o_st_mask (w_st_mask),
      .o_ld_data (w_ld_data)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid) w_state_nxt = (w_mem_op & ~w_misalign) ? ST_REQ : ST_DONE;
         ST_REQ:  if (mem_gnt)  w_state_nxt = mem_rvalid ? ST_DONE : ST_RESP;
         ST_RESP: if (mem_rvalid) w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Capture the instruction on accept and the load result on response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_lo   <= 2'b00;
         r_is_byte   <= 1'b0;
         r_write     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wen   <= 1'b0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
         r_wb_data   <= '0;
         r_reg_wen   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr_lo   <= in_addr[1:0];
            r_is_byte   <= w_is_byte;
            r_write     <= in_write;
            r_mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
            r_mem_wen   <= in_write;
            r_mem_wdata <= in_write ? w_st_data : '0;
            r_mem_wmask <= w_st_mask;
            // Memory ops start with zero; loads overwrite on response
            r_wb_data   <= w_mem_op ? '0 : in_addr;
            // Write wins over read, and stores/faults never write back
            r_reg_wen   <= in_reg_wen & ~in_write & ~w_misalign;
            r_err       <= w_misalign;
         end
         if (w_rsp & ~r_write) begin
            r_wb_data <= w_ld_data;
         end
      end
   end

   assign in_ready    = w_idle;
   assign out_valid   = (r_state == ST_DONE);
   assign out_wb_data = r_wb_data;
   assign out_reg_wen = r_reg_wen;
   assign out_err     = r_err;
   assign mem_req     = (r_state == ST_REQ);
   assign mem_addr    = r_mem_addr;
   assign mem_wen     = r_mem_wen;
   assign mem_wdata   = r_mem_wdata;
   assign mem_wmask   = r_mem_wmask;

endmodule : ysyx_25020047_lsu
`default_nettype wire

// File: tb/tb_ysyx_25020047_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25020047_lsu
//  Brief    : Directed self-checking bench for the LSU.
//  Options  : YSYX_25020047_LSU_MISALIGN_CHK_EN selects the misalign case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020047_lsu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst_type;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        in_read;
   logic        in_write;
   logic        in_reg_wen;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_wb_data;
   logic        out_reg_wen;
   logic        out_err;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   ysyx_25020047_lsu dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst_type (in_inst_type),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_read      (in_read),
      .in_write     (in_write),
      .in_reg_wen   (in_reg_wen),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_wb_data  (out_wb_data),
      .out_reg_wen  (out_reg_wen),
      .out_err      (out_err),
      .mem_req      (mem_req),
      .mem_gnt      (mem_gnt),
      .mem_addr     (mem_addr),
      .mem_wen      (mem_wen),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] it, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic rw);
      in_valid     = 1'b1;
      in_inst_type = it;
      in_addr      = a;
      in_wdata     = wd;
      in_read      = rd;
      in_write     = wr;
      in_reg_wen   = rw;
      tick();
      in_valid     = 1'b0;
      in_read      = 1'b0;
      in_write     = 1'b0;
      in_reg_wen   = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_inst_type = '0; in_addr = '0; in_wdata = '0;
      in_read = 1'b0; in_write = 1'b0; in_reg_wen = 1'b0;
      out_ready = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      // Reset values
      #12;
      check("rst_in_ready",  {31'b0, in_ready},    32'd1);
      check("rst_out_valid", {31'b0, out_valid},   32'd0);
      check("rst_wb_data",   out_wb_data,          32'd0);
      check("rst_reg_wen",   {31'b0, out_reg_wen}, 32'd0);
      check("rst_err",       {31'b0, out_err},     32'd0);
      check("rst_mem_req",   {31'b0, mem_req},     32'd0);
      check("rst_mem_wen",   {31'b0, mem_wen},     32'd0);
      check("rst_mem_addr",  mem_addr,             32'd0);
      check("rst_mem_wdata", mem_wdata,            32'd0);
      check("rst_mem_wmask", {28'b0, mem_wmask},   32'd0);
      rst = 1'b0;
      tick();

      // Pass-through: result visible the cycle after accept
      issue(32'h1, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 1'b1);
      check("addi_valid",   {31'b0, out_valid},   32'd1);
      check("addi_wb",      out_wb_data,          32'h5);
      check("addi_reg_wen", {31'b0, out_reg_wen}, 32'd1);
      check("addi_mem_req", {31'b0, mem_req},     32'd0);
      check("addi_in_rdy",  {31'b0, in_ready},    32'd0);
      handshake();
      check("addi_idle",    {31'b0, in_ready},    32'd1);
      check("addi_vld_low", {31'b0, out_valid},   32'd0);

      // lbu lane 3: gnt at T+1, rvalid at T+2, out_valid at T+3
      issue(32'h40, 32'h8000_0003, 32'h0, 1'b1, 1'b0, 1'b1);
      check("lbu_req",      {31'b0, mem_req},   32'd1);
      check("lbu_addr",     mem_addr,           32'h8000_0000);
      check("lbu_wen",      {31'b0, mem_wen},   32'd0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("lbu_req_drop", {31'b0, mem_req},   32'd0);
      check("lbu_vld_T2",   {31'b0, out_valid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      check("lbu_vld_T3",   {31'b0, out_valid},   32'd1);
      check("lbu_wb",       out_wb_data,          32'h0000_00AA);
      check("lbu_reg_wen",  {31'b0, out_reg_wen}, 32'd1);
      handshake();

      // sb lane 1 with gnt delayed three cycles
      issue(32'h100, 32'h8000_0001, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_gnt = 1'b1;
         check("sb_req",   {31'b0, mem_req},  32'd1);
         check("sb_wen",   {31'b0, mem_wen},  32'd1);
         check("sb_wmask", {28'b0, mem_wmask}, 32'h2);
         check("sb_wdata", mem_wdata,          32'h7878_7878);
         check("sb_addr",  mem_addr,           32'h8000_0000);
         tick();
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      check("sb_valid",   {31'b0, out_valid},   32'd1);
      check("sb_wb",      out_wb_data,          32'h0);
      check("sb_reg_wen", {31'b0, out_reg_wen}, 32'd0);
      handshake();

      // lw minimum latency then 4 cycles of backpressure with a pending input
      issue(32'h20, 32'h8000_0010, 32'h0, 1'b1, 1'b0, 1'b1);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      in_valid = 1'b1; in_inst_type = 32'h1; in_addr = 32'h0000_0777; in_reg_wen = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("lw_bp_valid",   {31'b0, out_valid},   32'd1);
         check("lw_bp_wb",      out_wb_data,          32'hDEAD_BEEF);
         check("lw_bp_reg_wen", {31'b0, out_reg_wen}, 32'd1);
         check("lw_bp_in_rdy",  {31'b0, in_ready},    32'd0);
         tick();
      end
      in_valid = 1'b0; in_reg_wen = 1'b0;
      handshake();
      check("lw_bp_released", {31'b0, out_valid}, 32'd0);
      check("lw_bp_in_ready", {31'b0, in_ready},  32'd1);

      // Reset while in REQ: mem_req drops before any clock edge
      issue(32'h20, 32'h8000_0040, 32'h0, 1'b1, 1'b0, 1'b1);
      check("rq_req_pre", {31'b0, mem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rq_req_async",  {31'b0, mem_req},   32'd0);
      check("rq_in_ready",   {31'b0, in_ready},  32'd1);
      check("rq_out_valid",  {31'b0, out_valid}, 32'd0);
      tick();
      rst = 1'b0;

      // Reset while in RESP, then a stray rvalid must be ignored
      issue(32'h20, 32'h8000_0044, 32'h0, 1'b1, 1'b0, 1'b1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rs_in_ready",  {31'b0, in_ready},  32'd1);
      check("rs_out_valid", {31'b0, out_valid}, 32'd0);
      check("rs_mem_req",   {31'b0, mem_req},   32'd0);
      tick();
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_rvalid = 1'b0;
      check("rs_stray_vld", {31'b0, out_valid}, 32'd0);
      check("rs_stray_rdy", {31'b0, in_ready},  32'd1);
      check("rs_stray_wb",  out_wb_data,        32'h0);

      // read and write both set: store wins, no write-back
      issue(32'h80, 32'h8000_0020, 32'hCAFE_BABE, 1'b1, 1'b1, 1'b1);
      check("rw_wen",   {31'b0, mem_wen},   32'd1);
      check("rw_wmask", {28'b0, mem_wmask}, 32'hF);
      check("rw_wdata", mem_wdata,          32'hCAFE_BABE);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check("rw_valid",   {31'b0, out_valid},   32'd1);
      check("rw_wb",      out_wb_data,          32'h0);
      check("rw_reg_wen", {31'b0, out_reg_wen}, 32'd0);
      handshake();

      // lbu lane 0, minimum latency
      issue(32'h40, 32'h8000_0004, 32'h0, 1'b1, 1'b0, 1'b1);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_56F0;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check("lbu0_valid", {31'b0, out_valid}, 32'd1);
      check("lbu0_wb",    out_wb_data,        32'h0000_00F0);
      handshake();

      // Misaligned word load
      issue(32'h20, 32'h8000_0002, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
      check("mis_req",     {31'b0, mem_req},     32'd0);
      check("mis_valid",   {31'b0, out_valid},   32'd1);
      check("mis_err",     {31'b0, out_err},     32'd1);
      check("mis_reg_wen", {31'b0, out_reg_wen}, 32'd0);
      check("mis_wb",      out_wb_data,          32'h0);
`else
      check("mis_req",  {31'b0, mem_req}, 32'd1);
      check("mis_addr", mem_addr,         32'h8000_0000);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check("mis_valid", {31'b0, out_valid}, 32'd1);
      check("mis_wb",    out_wb_data,        32'h1122_3344);
      check("mis_err",   {31'b0, out_err},   32'd0);
`endif
      handshake();
      check("end_idle", {31'b0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ysyx_25020047_lsu
`default_nettype wire

// File: doc/ysyx_25020047_lsu.md
# ysyx_25020047_lsu

Load/store unit sitting directly downstream of the execute stage. It takes the EXU's result (effective address or ALU value), the store operand and the read/write/reg-write flags. For memory instructions it runs a request/response transaction on the data-memory port. It then presents write-back data to the WBU through a valid/ready handshake, and passes non-memory results through in one cycle.

## Interface
- XLEN, 32, datapath and address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EXU outputs valid
- in_ready  out  1  LSU can accept; high only in IDLE
- in_inst_type  in  32  one-hot opcode: lw 0x20, lbu 0x40, sw 0x80, sb 0x100
- in_addr  in  XLEN  EXU result (effective address or ALU value)
- in_wdata  in  XLEN  store operand (rs2 value)
- in_read / in_write  in  1 each  memory access flags from EXU
- in_reg_wen  in  1  register write enable from EXU
- out_valid  out  1  write-back data valid
- out_ready  in  1  WBU accepts
- out_wb_data  out  XLEN  load data or passed-through result
- out_reg_wen  out  1  registered write enable
- out_err  out  1  misaligned access flag (0 when feature compiled out)
- mem_req  out  1  request valid
- mem_gnt  in  1  request accepted
- mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
- mem_wen  out  1  1 = store
- mem_wdata  out  XLEN  store data, byte-replicated for sb
- mem_wmask  out  4  byte strobes
- mem_rvalid  in  1  response / store ack
- mem_rdata  in  XLEN  read data word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - If in_read|in_write: go to REQ.
  - Otherwise go to DONE with wb_data=in_addr.
- REQ: mem_req=1 and mem_addr, mem_wen, mem_wdata and mem_wmask held stable until mem_gnt.
  - gnt without rvalid: go to RESP.
  - gnt with rvalid in the same cycle: go directly to DONE.
- RESP: wait for mem_rvalid, then go to DONE. Read data is captured on rvalid.
- DONE: out_valid=1; outputs held until out_ready, then return to IDLE.
- in_read and in_write both set: write takes priority, out_reg_wen forced to 0.
- Load extract:
  - lw: whole word.
  - lbu: byte lane in_addr[1:0], zero-extended to XLEN.
- Store pack:
  - sw: mask 4'hF, data unchanged.
  - sb: mask 1<<addr[1:0], data {4{wdata[7:0]}}.
- Stores: out_wb_data=0 and out_reg_wen=0, regardless of EXU flag.
- mem_rvalid outside REQ/RESP is ignored.
- mem_rdata is ignored for stores.

## Timing
- Reset values:
  - state IDLE
  - in_ready 1
  - out_valid 0, out_wb_data 0, out_reg_wen 0, out_err 0
  - mem_req 0, mem_wen 0, mem_addr 0, mem_wdata 0, mem_wmask 0
- Non-memory instruction: accepted at T, out_valid at T+1.
- Memory access, accepted at T: mem_req rises at T+1; with gnt at T+1 and rvalid at T+2, out_valid is at T+3.
- Minimum memory latency (gnt and rvalid both at T+1): out_valid at T+2.
- out_valid backpressure: holds indefinitely, and no new accept occurs.
- Reset mid-transaction: immediate return to IDLE, mem_req drops asynchronously, and the captured instruction is discarded.

## Configuration
- YSYX_25020047_LSU_MISALIGN_CHK_EN:
  - Defined: lw/sw with addr[1:0]≠0 issue no memory request and go IDLE→DONE with out_err=1, out_reg_wen=0 and out_wb_data=0. Byte accesses are never misaligned.
  - Undefined: low address bits are silently dropped for word accesses and out_err is tied 0.

## Structure
- Package ysyx_25020047_pkg holds:
  - inst_type one-hot constants (INST_LW, INST_LBU, INST_SW, INST_SB, …)
  - FSM state enum
  - byte-mask width constant
- Sub-module ysyx_25020047_lsu_align: combinational block computing load byte extraction and store data/mask from addr[1:0] and width.

## Test plan
- Addi pass-through: in_addr=0x00000005, reg_wen=1 → out_valid next cycle, wb_data=0x5, reg_wen=1, no mem_req.
- lbu at addr 0x80000003, mem_rdata=0xAABBCCDD, gnt at T+1, rvalid at T+2 → wb_data=0x000000AA, mem_addr=0x80000000, out_valid at T+3.
- sb at 0x80000001 with wdata=0x12345678, gnt delayed 3 cycles → mem_wmask=0b0010 and mem_wdata=0x78787878 held stable throughout REQ; reg_wen=0.
- lw with gnt and rvalid in the same cycle, out_ready held low 4 cycles → out_valid and data stable for those cycles, in_ready=0 until handshake completes.
- rst asserted while in RESP → mem_req=0, out_valid=0, in_ready=1 immediately; a later rvalid pulse is ignored.
- With MISALIGN_CHK_EN defined, lw at 0x80000002 → no mem_req, out_err=1, reg_wen=0 one cycle after accept.
